// File: rtl/mux_logic_pkg.sv
// Shared types for the mux-only logic unit: op codes and packet FSM states.
package mux_logic_pkg;

  typedef enum logic [1:0] {
    OP_OR   = 2'd0,
    OP_AND  = 2'd1,
    OP_XOR  = 2'd2,
    OP_PASS = 2'd3
  } op_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/mux2.sv
// Basic 2:1 multiplexer cell; the only logic primitive the unit is built from.
module mux2 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_logic_bit.sv
// One result bit of every op, composed purely from mux2 cells and constants.
module mux_logic_bit
  import mux_logic_pkg::*;
(
  input  logic a,
  input  logic b,
  input  op_t  op,
  output logic y
);

  logic [1:0] op_bits;
  logic       b_n;
  logic       r_or;
  logic       r_and;
  logic       r_xor;
  logic       r_lo;
  logic       r_hi;

  assign op_bits = op;

  mux2 u_not (.sel(b), .d0(1'b1), .d1(1'b0), .y(b_n));
  mux2 u_or  (.sel(a), .d0(b),    .d1(1'b1), .y(r_or));
  mux2 u_and (.sel(a), .d0(1'b0), .d1(b),    .y(r_and));
  mux2 u_xor (.sel(a), .d0(b),    .d1(b_n),  .y(r_xor));

  // Op select tree: op[0] picks within {OR,AND} / {XOR,PASS}, op[1] picks the pair.
  mux2 u_lo  (.sel(op_bits[0]), .d0(r_or),  .d1(r_and), .y(r_lo));
  mux2 u_hi  (.sel(op_bits[0]), .d0(r_xor), .d1(a),     .y(r_hi));
  mux2 u_out (.sel(op_bits[1]), .d0(r_lo),  .d1(r_hi),  .y(y));

endmodule

// File: rtl/mux_logic_unit.sv
// Streaming bitwise-op unit with optional packet accumulation and a single
// registered output stage (valid/ready on both sides).
module mux_logic_unit
  import mux_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             dbg_state
);

  // Handshake: a beat moves on a side when its valid and ready are both high
  // at the rising edge; in_ready is high whenever the output register is free
  // or being drained this cycle.

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] acc;
  op_t              sel_op;
  logic [WIDTH-1:0] opnd_x;
  logic [WIDTH-1:0] opnd_y;
  logic [WIDTH-1:0] res;
  logic             accept;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // Open packet: acc op in_a with the latched op. Seed beat swaps operands.
  always_comb begin
    sel_op = op_t'(in_op);
    opnd_x = in_a;
    opnd_y = in_b;
    if (state == ACC) begin
      sel_op = op_q;
      opnd_x = acc;
      opnd_y = in_a;
    end else if (in_acc) begin
      opnd_x = in_b;
      opnd_y = in_a;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_logic_bit u_bit (
      .a  (opnd_x[i]),
      .b  (opnd_y[i]),
      .op (sel_op),
      .y  (res[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= OP_OR;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (state == IDLE) begin
          if (!in_acc || in_last) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_last  <= in_acc ? 1'b1 : in_last;
          end else begin
            acc   <= res;
            op_q  <= op_t'(in_op);
            state <= ACC;
          end
        end else begin
          acc <= res;
          if (in_last) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_last  <= 1'b1;
            state     <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_logic_unit.sv
// Bench for mux_logic_unit: directed scenarios plus random traffic, checked
// against a packet-level reference model and an expected-output queue.
module tb_mux_logic_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         in_acc;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         dbg_state;

  mux_logic_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  logic [W:0]   exp_q[$];   // {last, data}
  bit           m_open;
  logic [W-1:0] m_acc;
  logic [1:0]   m_op;
  int           n_vec = 0;
  int           n_err = 0;

  function automatic logic [W-1:0] op_fn(input logic [1:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    case (op)
      2'd0:    return x | y;
      2'd1:    return x & y;
      2'd2:    return x ^ y;
      default: return x;
    endcase
  endfunction

  task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] op, input logic accf, input logic last);
    if (!m_open) begin
      if (!accf)     exp_q.push_back({last, op_fn(op, a, b)});
      else if (last) exp_q.push_back({1'b1, op_fn(op, b, a)});
      else begin
        m_acc  = op_fn(op, b, a);
        m_op   = op;
        m_open = 1'b1;
      end
    end else begin
      m_acc = op_fn(m_op, m_acc, a);
      if (last) begin
        exp_q.push_back({1'b1, m_acc});
        m_open = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_open = 1'b0;
    m_acc  = '0;
    m_op   = 2'd0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic accf, input logic last);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_acc   = accf;
    in_last  = last;
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic step();
    bit pend, hs, acc_beat;
    @(negedge clk);
    pend = (exp_q.size() != 0);
    chk("out_valid", out_valid, pend);
    chk("in_ready", in_ready, !pend || out_ready);
    if (pend) begin
      chk("out_data", out_data, exp_q[0][W-1:0]);
      chk("out_last", out_last, exp_q[0][W]);
    end
    hs       = pend && out_ready;
    acc_beat = in_valid && (!pend || out_ready);
    @(posedge clk);
    #1;
    if (hs) void'(exp_q.pop_front());
    if (acc_beat) model_beat(in_a, in_b, in_op, in_acc, in_last);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_data"}, out_data, '0);
    chk({tag, "_last"}, out_last, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    apply_reset("reset");
    step();

    // OR single beat: A0 | 0C = AC
    drive(1'b1, 8'hA0, 8'h0C, 2'd0, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    step();
    step();

    // XOR accumulate: seed FF, beats 0F, 33, 55 -> 96
    drive(1'b1, 8'h0F, 8'hFF, 2'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 8'h33, 8'h00, 2'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h55, 8'hAA, 2'd0, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    step();
    step();

    // AND single-beat accumulate: F0 & 3C = 30
    drive(1'b1, 8'hF0, 8'h3C, 2'd1, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    step();

    // Back-pressure: hold for 3 cycles, next beat offered throughout
    drive(1'b1, 8'h5A, 8'h0F, 2'd2, 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    drive(1'b1, 8'h12, 8'h34, 2'd3, 1'b0, 1'b1);
    repeat (3) step();
    out_ready = 1'b1;
    step();
    drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    step();
    step();

    // Reset mid-packet after two accumulate beats, then a fresh OR beat
    drive(1'b1, 8'h11, 8'h22, 2'd0, 1'b1, 1'b0);
    step();
    drive(1'b1, 8'h44, 8'h00, 2'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    apply_reset("midreset");
    drive(1'b1, 8'h01, 8'h02, 2'd0, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    step();
    step();

    // 16 back-to-back non-accumulate beats
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'b0,
            1'($urandom_range(0, 1)));
      step();
    end
    drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    step();
    step();

    // Random mixed packets with random stalls on both sides
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
            2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0));
      step();
    end
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
